// File: rtl/capture_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : capture_ctrl_if
//  Description : Probe/control inputs and sample-RAM write-port outputs of the
//                trace-capture sequencer, bundled as one interface.
//  Revision    : 1.0 - initial release
// ============================================================================
interface capture_ctrl_if #(
  parameter int ADRBITS  = 12,
  parameter int DATABITS = 16
);
  logic [DATABITS-1:0] Probe;
  logic                Trigger;
  logic                Arm;
  logic [ADRBITS-1:0]  PreCount;
  logic [ADRBITS-1:0]  PostCount;
  logic [ADRBITS-1:0]  WrAddress;
  logic [DATABITS-1:0] Data;
  logic                WE;
  logic                WrClockEn;
  logic                Busy;
  logic                Triggered;
  logic                Done;
  logic [ADRBITS-1:0]  StartAddress;
  logic [ADRBITS-1:0]  TrigAddress;

  // Sequencer side: consumes probe/control, drives the RAM write port and status
  modport master (
    input  Probe, Trigger, Arm, PreCount, PostCount,
    output WrAddress, Data, WE, WrClockEn, Busy, Triggered, Done,
           StartAddress, TrigAddress
  );

  // Environment side: drives probe/control, observes RAM write port and status
  modport slave (
    output Probe, Trigger, Arm, PreCount, PostCount,
    input  WrAddress, Data, WE, WrClockEn, Busy, Triggered, Done,
           StartAddress, TrigAddress
  );
endinterface
`default_nettype wire

// File: rtl/capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : capture_ctrl
//  Description : Trace-capture sequencer. Writes the probe bus into a circular
//                sample RAM every clock, keeps PreCount samples of history,
//                stops PostCount samples after the trigger and reports the
//                address of the oldest valid sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module capture_ctrl #(
  parameter int ADRBITS  = 12,
  parameter int DATABITS = 16
) (
  input  wire logic         Clock,
  input  wire logic         Reset,
  capture_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADRBITS-1:0]  wptr_q, wptr_d;
  logic [ADRBITS-1:0]  cnt_q, cnt_d;
  logic [ADRBITS-1:0]  pre_q, pre_d;
  logic [ADRBITS-1:0]  post_q, post_d;
  logic [ADRBITS-1:0]  wraddr_q, wraddr_d;
  logic [DATABITS-1:0] data_q, data_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                triggered_q, triggered_d;
  logic                done_q, done_d;
  logic [ADRBITS-1:0]  start_q, start_d;
  logic [ADRBITS-1:0]  trig_q, trig_d;
  logic [ADRBITS-1:0]  cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  // Next-state and registered-output computation; Arm overrides every state
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    cnt_d       = cnt_q;
    pre_d       = pre_q;
    post_d      = post_q;
    wraddr_d    = wraddr_q;
    data_d      = data_q;
    we_d        = 1'b0;
    triggered_d = triggered_q;
    done_d      = done_q;
    start_d     = start_q;
    trig_d      = trig_q;

    if (bus.Arm) begin
      // Restart from scratch; no sample is written on the Arm edge and a
      // coincident Trigger is deliberately dropped.
      pre_d       = bus.PreCount;
      post_d      = bus.PostCount;
      wptr_d      = '0;
      cnt_d       = '0;
      triggered_d = 1'b0;
      done_d      = 1'b0;
      state_d     = (bus.PreCount == '0) ? S_ARMED : S_FILL;
    end else begin
      if ((state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST)) begin
        we_d     = 1'b1;
        data_d   = bus.Probe;
        wraddr_d = wptr_q;
        wptr_d   = wptr_q + 1'b1;
      end
      case (state_q)
        S_FILL: begin
          // Trigger is not looked at here so the history depth is guaranteed
          cnt_d = cnt_inc;
          if (cnt_inc == pre_q) begin
            cnt_d   = '0;
            state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          if (bus.Trigger) begin
            trig_d      = wptr_q;
            triggered_d = 1'b1;
            cnt_d       = '0;
            state_d     = (post_q == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          cnt_d = cnt_inc;
          if (cnt_inc == post_q) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          // First DONE edge is the one committing the last sample to RAM
          if (!done_q) begin
            done_d  = 1'b1;
            start_d = trig_q - pre_q;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    busy_d = (state_d == S_FILL) || (state_d == S_ARMED) || (state_d == S_POST);
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      cnt_q       <= '0;
      pre_q       <= '0;
      post_q      <= '0;
      wraddr_q    <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      start_q     <= '0;
      trig_q      <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      post_q      <= post_d;
      wraddr_q    <= wraddr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
      start_q     <= start_d;
      trig_q      <= trig_d;
    end
  end

  assign bus.WrAddress    = wraddr_q;
  assign bus.Data         = data_q;
  assign bus.WE           = we_q;
  assign bus.WrClockEn    = 1'b1;
  assign bus.Busy         = busy_q;
  assign bus.Triggered    = triggered_q;
  assign bus.Done         = done_q;
  assign bus.StartAddress = start_q;
  assign bus.TrigAddress  = trig_q;

endmodule
`default_nettype wire

// File: tb/tb_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_capture_ctrl
//  Description : Directed self-checking bench for capture_ctrl with a small
//                behavioural sample RAM on the write port (adrbits=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_ctrl;

  localparam int ADRBITS  = 4;
  localparam int DATABITS = 16;

  logic Clock;
  logic Reset;
  int   checks   = 0;
  int   failures = 0;

  capture_ctrl_if #(.ADRBITS(ADRBITS), .DATABITS(DATABITS)) bus ();

  capture_ctrl #(.ADRBITS(ADRBITS), .DATABITS(DATABITS)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.master)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Behavioural sample RAM: commits on the edge after WE/Data/WrAddress register
  logic [DATABITS-1:0] mem [0:(1<<ADRBITS)-1];
  logic [ADRBITS-1:0]  last_addr = '0;
  int                  wr_count  = 0;
  always @(posedge Clock) begin
    if (bus.WE && bus.WrClockEn) begin
      mem[bus.WrAddress] <= bus.Data;
      last_addr          <= bus.WrAddress;
      wr_count           <= wr_count + 1;
    end
  end

  // One clock; Probe behaves as a cycle counter
  task automatic tick();
    @(posedge Clock);
    #1;
    bus.Probe = bus.Probe + 16'd1;
  endtask

  task automatic arm();
    bus.Arm = 1'b1;
    tick();
    bus.Arm = 1'b0;
  endtask

  // Wait for Done with a cycle budget
  task automatic wait_done(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 40) begin
      tick();
      n++;
      if (bus.Done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.WE !== 1'b0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Triggered !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: WE=%b Busy=%b Done=%b Triggered=%b, required all 0",
               bus.WE, bus.Busy, bus.Done, bus.Triggered);
    end
    checks++;
    if (bus.WrClockEn !== 1'b1) begin
      failures++;
      $display("FAIL reset_wrclken: got %b, required 1", bus.WrClockEn);
    end
    checks++;
    if (bus.WrAddress !== 4'd0 || bus.Data !== 16'd0 || bus.StartAddress !== 4'd0 || bus.TrigAddress !== 4'd0) begin
      failures++;
      $display("FAIL reset_values: WrAddress=%0d Data=%0d Start=%0d Trig=%0d, required all 0",
               bus.WrAddress, bus.Data, bus.StartAddress, bus.TrigAddress);
    end
  endtask

  task automatic test_basic();
    logic [DATABITS-1:0] trig_val;
    logic                prev_we;
    int                  n;
    bit                  got;
    bus.PreCount  = 4'd3;
    bus.PostCount = 4'd4;
    arm();
    checks++;
    if (bus.WE !== 1'b0 || bus.Busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_arm_edge: WE=%b Busy=%b, required WE=0 Busy=1", bus.WE, bus.Busy);
    end
    repeat (5) tick();
    trig_val    = bus.Probe;
    bus.Trigger = 1'b1;
    tick();
    bus.Trigger = 1'b0;
    checks++;
    if (bus.Triggered !== 1'b1 || bus.TrigAddress !== 4'd5 || bus.WrAddress !== 4'd5) begin
      failures++;
      $display("FAIL basic_trigger: Triggered=%b TrigAddress=%0d WrAddress=%0d, required 1/5/5",
               bus.Triggered, bus.TrigAddress, bus.WrAddress);
    end
    prev_we = bus.WE;
    n       = 0;
    got     = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      if (bus.Done === 1'b1) got = 1'b1;
      else prev_we = bus.WE;
    end
    checks++;
    if (!got || n != 5) begin
      failures++;
      $display("FAIL basic_done_latency: got=%0d edges=%0d, required done after 5 edges", got, n);
    end
    checks++;
    if (prev_we !== 1'b1 || bus.WE !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_we: WE before=%b WE at Done=%b, required 1 then 0", prev_we, bus.WE);
    end
    checks++;
    if (bus.StartAddress !== 4'd2 || bus.TrigAddress !== 4'd5 || bus.Busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_addresses: Start=%0d Trig=%0d Busy=%b, required 2/5/0",
               bus.StartAddress, bus.TrigAddress, bus.Busy);
    end
    for (int a = 2; a <= 9; a++) begin
      checks++;
      if (mem[a] !== 16'(int'(trig_val) + a - 5)) begin
        failures++;
        $display("FAIL basic_ram[%0d]: got %0d, required %0d", a, mem[a], 16'(int'(trig_val) + a - 5));
      end
    end
  endtask

  task automatic test_early_trigger();
    int n;
    bit ok;
    bus.PreCount  = 4'd5;
    bus.PostCount = 4'd2;
    bus.Trigger   = 1'b1;
    arm();
    n = 0;
    while (bus.Triggered !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    bus.Trigger = 1'b0;
    checks++;
    if (n != 6 || bus.TrigAddress !== 4'd5) begin
      failures++;
      $display("FAIL early_trigger: edges=%0d TrigAddress=%0d, required 6/5", n, bus.TrigAddress);
    end
    wait_done(n, ok);
    checks++;
    if (!ok || bus.StartAddress !== 4'd0) begin
      failures++;
      $display("FAIL early_start: done=%0d Start=%0d, required 1/0", ok, bus.StartAddress);
    end
  endtask

  task automatic test_wrap();
    logic [DATABITS-1:0] trig_val;
    int                  n;
    bit                  ok;
    bus.PreCount  = 4'd4;
    bus.PostCount = 4'd6;
    arm();
    repeat (24) tick();
    trig_val    = bus.Probe;
    bus.Trigger = 1'b1;
    tick();
    bus.Trigger = 1'b0;
    checks++;
    if (bus.TrigAddress !== 4'd8) begin
      failures++;
      $display("FAIL wrap_trig: TrigAddress=%0d, required 8", bus.TrigAddress);
    end
    wait_done(n, ok);
    checks++;
    if (!ok || n != 7 || bus.StartAddress !== 4'd4) begin
      failures++;
      $display("FAIL wrap_done: done=%0d edges=%0d Start=%0d, required 1/7/4", ok, n, bus.StartAddress);
    end
    checks++;
    if (last_addr !== 4'd14) begin
      failures++;
      $display("FAIL wrap_last_addr: got %0d, required 14", last_addr);
    end
    checks++;
    if (mem[8] !== trig_val || mem[14] !== trig_val + 16'd6) begin
      failures++;
      $display("FAIL wrap_ram: mem[8]=%0d mem[14]=%0d, required %0d/%0d",
               mem[8], mem[14], trig_val, trig_val + 16'd6);
    end
  endtask

  task automatic test_zero_counts();
    int base;
    bus.PreCount  = 4'd0;
    bus.PostCount = 4'd0;
    base = wr_count;
    arm();
    bus.Trigger = 1'b1;
    tick();
    bus.Trigger = 1'b0;
    checks++;
    if (bus.WE !== 1'b1 || bus.WrAddress !== 4'd0 || bus.Done !== 1'b0 || bus.Triggered !== 1'b1) begin
      failures++;
      $display("FAIL zero_write: WE=%b WrAddress=%0d Done=%b Triggered=%b, required 1/0/0/1",
               bus.WE, bus.WrAddress, bus.Done, bus.Triggered);
    end
    tick();
    checks++;
    if (bus.Done !== 1'b1 || bus.WE !== 1'b0 || bus.StartAddress !== 4'd0 || bus.TrigAddress !== 4'd0) begin
      failures++;
      $display("FAIL zero_done: Done=%b WE=%b Start=%0d Trig=%0d, required 1/0/0/0",
               bus.Done, bus.WE, bus.StartAddress, bus.TrigAddress);
    end
    tick();
    checks++;
    if (wr_count - base != 1) begin
      failures++;
      $display("FAIL zero_write_count: got %0d, required 1", wr_count - base);
    end
  endtask

  task automatic test_abort();
    bus.PreCount  = 4'd2;
    bus.PostCount = 4'd8;
    arm();
    tick();
    tick();
    bus.Trigger = 1'b1;
    tick();
    bus.Trigger = 1'b0;
    tick();
    tick();
    bus.PreCount  = 4'd1;
    bus.PostCount = 4'd1;
    arm();
    checks++;
    if (bus.WE !== 1'b0 || bus.Triggered !== 1'b0 || bus.Done !== 1'b0 || bus.Busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_edge: WE=%b Triggered=%b Done=%b Busy=%b, required 0/0/0/1",
               bus.WE, bus.Triggered, bus.Done, bus.Busy);
    end
    tick();
    checks++;
    if (bus.WE !== 1'b1 || bus.WrAddress !== 4'd0) begin
      failures++;
      $display("FAIL abort_restart: WE=%b WrAddress=%0d, required 1/0", bus.WE, bus.WrAddress);
    end
    bus.Trigger = 1'b1;
    tick();
    bus.Trigger = 1'b0;
    checks++;
    if (bus.WrAddress !== 4'd1 || bus.TrigAddress !== 4'd1 || bus.Triggered !== 1'b1) begin
      failures++;
      $display("FAIL abort_trig: WrAddress=%0d Trig=%0d Triggered=%b, required 1/1/1",
               bus.WrAddress, bus.TrigAddress, bus.Triggered);
    end
    tick();
    tick();
    checks++;
    if (bus.Done !== 1'b1 || bus.StartAddress !== 4'd0) begin
      failures++;
      $display("FAIL abort_done: Done=%b Start=%0d, required 1/0", bus.Done, bus.StartAddress);
    end
  endtask

  task automatic test_async_reset();
    bit bad;
    bus.PreCount  = 4'd6;
    bus.PostCount = 4'd2;
    arm();
    tick();
    tick();
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (bus.WE !== 1'b0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Triggered !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: WE=%b Busy=%b Done=%b Triggered=%b, required all 0",
               bus.WE, bus.Busy, bus.Done, bus.Triggered);
    end
    #1;
    Reset = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (bus.Busy !== 1'b0 || bus.WE !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_stays_idle: Busy=%b WE=%b, required 0/0 until Arm", bus.Busy, bus.WE);
    end
  endtask

  initial begin
    Reset         = 1'b1;
    bus.Probe     = '0;
    bus.Trigger   = 1'b0;
    bus.Arm       = 1'b0;
    bus.PreCount  = '0;
    bus.PostCount = '0;
    tick();
    tick();
    test_reset();
    Reset = 1'b0;
    tick();
    test_basic();
    test_early_trigger();
    test_wrap();
    test_zero_counts();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Trace-capture sequencer that sits directly upstream of the on-chip sample buffer RAM and drives its write port (WrAddress, Data, WE, WrClockEn).
- Samples a probe bus every clock into a circular buffer.
- Keeps a programmable pre-trigger history and stops after a programmable number of post-trigger samples.
- Reports where the oldest valid sample lives, so the readout logic can walk the buffer in order on the RAM read port.

Parameters:
adrbits, 12, buffer address width; depth = 2^adrbits samples
databits, 16, probe/sample width

Ports:
Clock  input  1  single system clock; also drives the RAM write clock
Reset  input  1  asynchronous, active-high reset
Probe  input  databits  signals under observation, sampled every Clock edge
Trigger  input  1  trigger condition from the upstream comparator, sampled on the same edge as Probe
Arm  input  1  single-cycle start/restart pulse
PreCount  input  adrbits  number of samples captured before the trigger sample; latched on Arm
PostCount  input  adrbits  number of samples captured after the trigger sample; latched on Arm
WrAddress  output  adrbits  RAM write address (registered)
Data  output  databits  RAM write data (registered copy of Probe)
WE  output  1  RAM write enable (registered)
WrClockEn  output  1  RAM write clock enable; tied to 1
Busy  output  1  high in FILL, ARMED and POST
Triggered  output  1  high from the trigger edge until the next Arm
Done  output  1  capture complete; all samples are committed to RAM
StartAddress  output  adrbits  address of the oldest valid sample; valid while Done=1
TrigAddress  output  adrbits  address holding the trigger sample

Behaviour:
- Reset (async, high) puts the block in IDLE. All outputs go to 0 except WrClockEn, which stays 1. Internal wptr and cnt clear to 0.
- States: IDLE, FILL, ARMED, POST, DONE.
- Write-port timing: in FILL, ARMED and POST each edge does the following:
  - WE<=1, Data<=Probe, WrAddress<=wptr, wptr<=wptr+1.
  - The RAM commits the sample on the following edge, so capture-to-RAM latency is 2 edges.
- In IDLE and DONE: WE<=0; Data and WrAddress hold their last value.
- wptr wraps modulo 2^adrbits with no stall. Older samples are silently overwritten.
- IDLE, Arm=1:
  - Latch PreCount and PostCount; wptr<=0, cnt<=0; clear Triggered and Done.
  - Next state is FILL, or ARMED if PreCount=0.
  - No sample is written on the Arm edge.
- FILL:
  - Writes a sample each edge; cnt<=cnt+1.
  - When cnt+1==PreCount, next state is ARMED and cnt<=0.
  - Trigger is ignored in FILL, so the pre-trigger history is guaranteed.
- ARMED:
  - Writes a sample each edge.
  - If Trigger=1 on that edge: TrigAddress<=wptr (the trigger sample itself), Triggered<=1, cnt<=0.
  - Next state is POST, or DONE if PostCount=0.
- POST:
  - Writes a sample each edge; cnt<=cnt+1.
  - When cnt+1==PostCount, next state is DONE.
- DONE:
  - Done<=1 on the first edge in DONE. That is the edge that commits the last sample, and the same edge where WE drops to 0.
  - StartAddress = TrigAddress - PreCount (mod 2^adrbits), registered together with Done.
- Busy is registered and tracks the state: 1 in FILL, ARMED and POST.
- Arm while Busy or Done aborts the capture and restarts it exactly as from IDLE. On that edge WE<=0, Triggered<=0, Done<=0.
- Arm and Trigger on the same edge: Arm wins and Trigger is ignored.
- Constraint: PreCount+PostCount+1 <= 2^adrbits.
  - If it is exceeded, the capture still completes.
  - StartAddress is then computed by the same formula; the oldest samples are overwritten and no flag is raised.
- Reset asserted mid-capture: immediate return to IDLE with WE=0. A write in flight on that edge is not guaranteed to be committed.
- All arithmetic is unsigned adrbits-wide and modulo 2^adrbits.

Test Plan:
- Basic capture (adrbits=4, PreCount=3, PostCount=4), Probe = cycle counter, Trigger on the 6th write edge:
  - TrigAddress=5, StartAddress=2.
  - RAM[2..9] hold 8 consecutive Probe values with the trigger value at address 5.
  - Done rises exactly when WE falls.
- Early trigger ignored: PreCount=5, Trigger held high from Arm onward:
  - Trigger is taken on the first ARMED edge, so TrigAddress=5 and StartAddress=0.
- Wrap-around: adrbits=4, PreCount=4, PostCount=6, trigger after 20 ARMED writes:
  - TrigAddress=(4+20) mod 16=8, StartAddress=4.
  - Last write lands at address 14.
- Zero counts: PreCount=0, PostCount=0, Trigger on the first ARMED edge:
  - Exactly one write, to address 0.
  - Done one edge later; StartAddress=0 and TrigAddress=0.
- Abort: Arm pulsed again mid-POST:
  - Same edge: WE=0, Triggered=0, Done=0.
  - The capture restarts from wptr=0 with the newly latched counts.
- Async reset mid-FILL:
  - WE, Busy, Done and Triggered are 0 before the next Clock edge.
  - The block stays in IDLE until Arm.
